food_placer: RTL and testbench
==============================

# food_placer

Food placement controller that sits directly downstream of the LFSR food-coordinate generator. On game start or when the snake eats, it steps the generator once, then scans the snake body memory for an overlap with the new candidate. It re-rolls on a collision and publishes a validated food position to the renderer and the eat detector.

## Interface
Parameters:
- MAX_LEN, 32: maximum snake segments; sets the seg_addr width to clog2(MAX_LEN).
- COORD_W, 7: coordinate width; matches the generator's x/y outputs.
- MAX_RETRY, 15: maximum re-rolls per placement before the block accepts a colliding candidate.

Ports:
- CLOCK  in  1  single system clock; all logic is on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  game-start pulse; begins or restarts a placement.
- eat  in  1  head-on-food pulse; begins a placement when idle.
- cand_x, cand_y  in  COORD_W  candidate position from the generator.
- rand_step  out  1  one-cycle pulse to the generator's advance input; the generator shifts its LFSR once per high cycle.
- snake_len  in  clog2(MAX_LEN)+1  current number of body segments.
- seg_addr  out  clog2(MAX_LEN)  body-memory read address.
- seg_x, seg_y  in  COORD_W  body-memory read data; synchronous, 1-cycle latency.
- food_x, food_y  out  COORD_W  validated food position.
- food_valid  out  1  high while food_x/food_y hold a placed position.
- busy  out  1  high in any state other than IDLE.
- place_fail  out  1  sticky; set when the retry limit is exhausted, cleared at the next request.

## Operation
State machine states: IDLE, STEP, LATCH, SCAN.
- IDLE:
  - start or eat → STEP.
  - On entry to STEP: food_valid←0, retry←0, place_fail←0.
- STEP:
  - rand_step=1, decoded from the state; high for exactly this one cycle.
  - Next state is LATCH unconditionally.
- LATCH:
  - The generator output has updated; capture cand_x/cand_y into cand registers.
  - len_r←min(snake_len, MAX_LEN); idx←0.
  - Next state is SCAN.
- SCAN, read and compare pipeline:
  - Each cycle with idx<len_r: drive seg_addr=idx, idx++, and set rd_vld for the next cycle.
  - Each cycle with rd_vld: compare {seg_x,seg_y} with the cand registers.
- SCAN exits:
  - Hit with retry<MAX_RETRY: retry++, abort the scan, go to STEP.
  - Hit with retry==MAX_RETRY: place_fail←1, then complete as below.
  - Scan complete (idx==len_r and no rd_vld pending, or the exhausted-retry hit above): food_x/food_y←cand registers, food_valid←1, go to IDLE.
- Only full (x,y) equality is a hit. Compares are unsigned, width COORD_W, with no arithmetic on coordinates.
- seg_addr holds its last value when not scanning; 0 after reset.

Boundary conditions:
- eat while busy: ignored and not queued.
- start while busy: restart. Go to STEP, retry←0, food_valid stays 0, any in-flight rd_vld is discarded.
- start and eat in the same cycle: treated as start.
- snake_len=0: no reads; placement completes at the SCAN exit with no compares.
- snake_len>MAX_LEN: clamped to MAX_LEN.
- snake_len changing mid-scan: no effect, because len_r is sampled in LATCH.
- RESET_N asserted at any point: immediate return to IDLE.

## Timing
- Reset values: state=IDLE, rand_step=0, seg_addr=0, food_x=0, food_y=0, food_valid=0, busy=0, place_fail=0.
- Request sampled at edge E0; rand_step is high in cycle E0→E1; cand is captured at E2.
- Collision-free placement: food_valid rises at edge E0+len_r+3.
- Each retry costs 2 cycles (STEP, LATCH) plus the scan up to and including the hit compare.
- Worst case: (MAX_RETRY+1)·(MAX_LEN+3) cycles.
- food_x/food_y are stable whenever food_valid=1 and change only on the edge that sets food_valid.

## Structure
- Shared package holds:
  - the state enum (IDLE, STEP, LATCH, SCAN);
  - COORD_W and MAX_LEN defaults;
  - the seg-address width function.
- No sub-module: the comparator and the scan counter are a few lines each and stay inline.
- The generator and the body memory are external. This block only drives rand_step and seg_addr.

## Test plan
- Reset, then start with snake_len=3 and body at (20,4),(22,4),(24,4); generator stepped to cand (50,30):
  - rand_step is a 1-cycle pulse;
  - food_valid rises at E0+6;
  - food=(50,30); place_fail=0.
- First candidate (22,4) collides with the body, second candidate (40,10) is clear:
  - exactly two rand_step pulses;
  - food=(40,10);
  - the first scan aborts on the compare of idx 1.
- Body covers every generator output (stub generator fixed at (18,2), body contains (18,2)):
  - MAX_RETRY+1=16 rand_step pulses;
  - place_fail=1; food=(18,2); food_valid=1.
- eat pulsed while busy:
  - no extra rand_step pulse;
  - placement completes with its original timing.
- start pulsed mid-SCAN:
  - scan aborts and a new STEP follows on the next cycle;
  - retry count is reset, checked with a colliding run reaching exactly 16 pulses.
- RESET_N asserted mid-SCAN, then released:
  - all outputs return to reset values immediately;
  - the block stays in IDLE until the next start or eat.

Source files
------------

// File: rtl/food_placer_pkg.sv
// rtl/food_placer_pkg.sv - shared types, defaults and helpers for the food placer
package food_placer_pkg;

    localparam int DEF_MAX_LEN   = 32;
    localparam int DEF_COORD_W   = 7;
    localparam int DEF_MAX_RETRY = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        LATCH = 2'd2,
        SCAN  = 2'd3
    } state_t;

    // Width of the body-memory address for a given segment capacity.
    function automatic int seg_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/food_placer.sv
// rtl/food_placer.sv - steps the coordinate generator and re-rolls until food misses the snake body
module food_placer
    import food_placer_pkg::*;
#(
    parameter int MAX_LEN   = DEF_MAX_LEN,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic                       CLOCK,
    input  logic                       RESET_N,
    input  logic                       start,
    input  logic                       eat,
    input  logic [COORD_W-1:0]         cand_x,
    input  logic [COORD_W-1:0]         cand_y,
    output logic                       rand_step,
    input  logic [seg_aw(MAX_LEN):0]   snake_len,
    output logic [seg_aw(MAX_LEN)-1:0] seg_addr,
    input  logic [COORD_W-1:0]         seg_x,
    input  logic [COORD_W-1:0]         seg_y,
    output logic [COORD_W-1:0]         food_x,
    output logic [COORD_W-1:0]         food_y,
    output logic                       food_valid,
    output logic                       busy,
    output logic                       place_fail
);

    localparam int AW = seg_aw(MAX_LEN);
    localparam int LW = AW + 1;
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t             state;
    logic [COORD_W-1:0] cand_xr;
    logic [COORD_W-1:0] cand_yr;
    logic [LW-1:0]      len_r;
    logic [LW-1:0]      idx;
    logic [LW-1:0]      idx_nxt;
    logic [LW-1:0]      len_clamp;
    logic [RW-1:0]      retry;
    logic               rd_vld;
    logic               hit;

    // The generator advances once per STEP cycle; busy covers every non-idle state.
    assign rand_step = (state == STEP);
    assign busy      = (state != IDLE);

    assign len_clamp = (snake_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : snake_len;
    assign idx_nxt   = idx + LW'(1);
    assign hit       = rd_vld && (seg_x == cand_xr) && (seg_y == cand_yr);

    // Placement FSM with the inline scan counter and read-valid pipeline stage.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            cand_xr    <= '0;
            cand_yr    <= '0;
            len_r      <= '0;
            idx        <= '0;
            retry      <= '0;
            rd_vld     <= 1'b0;
            seg_addr   <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            place_fail <= 1'b0;
        end else if (start && (state != IDLE)) begin
            // Restart: drop whatever scan was in flight and roll again from scratch.
            state      <= STEP;
            retry      <= '0;
            rd_vld     <= 1'b0;
            place_fail <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start || eat) begin
                        state      <= STEP;
                        food_valid <= 1'b0;
                        retry      <= '0;
                        place_fail <= 1'b0;
                    end
                end
                STEP: begin
                    state <= LATCH;
                end
                LATCH: begin
                    cand_xr <= cand_x;
                    cand_yr <= cand_y;
                    len_r   <= len_clamp;
                    idx     <= '0;
                    rd_vld  <= 1'b0;
                    if (len_clamp != '0) begin
                        seg_addr <= '0;
                    end
                    state   <= SCAN;
                end
                SCAN: begin
                    if (hit && (retry < RW'(MAX_RETRY))) begin
                        retry  <= retry + RW'(1);
                        rd_vld <= 1'b0;
                        state  <= STEP;
                    end else if (hit || (idx == len_r)) begin
                        // Either the last compare missed, there was nothing to read,
                        // or the retry budget is spent and the collision is accepted.
                        if (hit) begin
                            place_fail <= 1'b1;
                        end
                        food_x     <= cand_xr;
                        food_y     <= cand_yr;
                        food_valid <= 1'b1;
                        rd_vld     <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        // Address for idx is already on seg_addr; queue its compare.
                        idx    <= idx_nxt;
                        rd_vld <= 1'b1;
                        if (idx_nxt < len_r) begin
                            seg_addr <= idx_nxt[AW-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_food_placer.sv
// tb/tb_food_placer.sv - scoreboard bench for food_placer with stub generator and body memory
module tb_food_placer;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       start = 1'b0;
    logic       eat = 1'b0;
    logic [6:0] cand_x;
    logic [6:0] cand_y;
    logic       rand_step;
    logic [5:0] snake_len = 6'd3;
    logic [4:0] seg_addr;
    logic [6:0] seg_x = '0;
    logic [6:0] seg_y = '0;
    logic [6:0] food_x;
    logic [6:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       place_fail;

    food_placer dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .start      (start),
        .eat        (eat),
        .cand_x     (cand_x),
        .cand_y     (cand_y),
        .rand_step  (rand_step),
        .snake_len  (snake_len),
        .seg_addr   (seg_addr),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .busy       (busy),
        .place_fail (place_fail)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int fx;
        int fy;
        int fail;
        int steps;
        int lat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   req_cyc = 0;
    int   step_total = 0;
    int   step_base = 0;
    int   gen_i = 0;
    int   gen_base = 0;
    int   gen_off;
    logic [6:0] mem_x [32];
    logic [6:0] mem_y [32];
    logic [6:0] gtab_x [4];
    logic [6:0] gtab_y [4];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Stub generator: offset 1 is the first candidate after a request, offset 3+ repeats.
    assign gen_off = gen_i - gen_base;
    assign cand_x  = gtab_x[(gen_off > 3) ? 3 : gen_off];
    assign cand_y  = gtab_y[(gen_off > 3) ? 3 : gen_off];

    always @(posedge CLOCK) begin
        cyc <= cyc + 1;
        if (rand_step) gen_i <= gen_i + 1;
        seg_x <= mem_x[seg_addr];
        seg_y <= mem_y[seg_addr];
    end

    // Monitor: counts generator pulses and scores each newly published food position.
    logic prev_valid = 1'b0;
    logic prev_step = 1'b0;
    always @(negedge CLOCK) begin
        exp_t e;
        if (rand_step) begin
            step_total = step_total + 1;
            check("step_pulse_width", int'(prev_step), 0);
        end
        if (food_valid && !prev_valid) begin
            if (q.size() == 0) begin
                check("unexpected_food", 1, 0);
            end else begin
                e = q.pop_front();
                check("food_x", int'(food_x), e.fx);
                check("food_y", int'(food_y), e.fy);
                check("place_fail", int'(place_fail), e.fail);
                check("step_count", step_total - step_base, e.steps);
                check("latency", cyc - req_cyc, e.lat);
            end
        end
        prev_valid = food_valid;
        prev_step  = rand_step;
    end

    task automatic set_gen(input int x1, input int y1, input int x2, input int y2);
        gtab_x[0] = 7'd0;      gtab_y[0] = 7'd0;
        gtab_x[1] = 7'(x1);    gtab_y[1] = 7'(y1);
        gtab_x[2] = 7'(x2);    gtab_y[2] = 7'(y2);
        gtab_x[3] = 7'(x2);    gtab_y[3] = 7'(y2);
    endtask

    // Called at posedge+2; the request is sampled at the next edge (E0).
    task automatic issue(input bit s, input bit e, input bit push, input int fx, input int fy,
                         input int fail, input int steps, input int lat);
        exp_t x;
        start     = s;
        eat       = e;
        step_base = step_total;
        gen_base  = gen_i;
        req_cyc   = cyc + 1;
        if (push) begin
            x.fx = fx; x.fy = fy; x.fail = fail; x.steps = steps; x.lat = lat;
            q.push_back(x);
        end
        @(posedge CLOCK);
        #2;
        start = 1'b0;
        eat   = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge CLOCK);
            if (food_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("placement_timeout", 0, 1);
        @(posedge CLOCK);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rand_step"}, int'(rand_step), 0);
        check({tag, "_seg_addr"}, int'(seg_addr), 0);
        check({tag, "_food_x"}, int'(food_x), 0);
        check({tag, "_food_y"}, int'(food_y), 0);
        check({tag, "_food_valid"}, int'(food_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_place_fail"}, int'(place_fail), 0);
    endtask

    initial begin
        int saved;
        for (int i = 0; i < 32; i++) begin
            mem_x[i] = 7'(i);
            mem_y[i] = 7'd120;
        end
        mem_x[0] = 7'd20; mem_y[0] = 7'd4;
        mem_x[1] = 7'd22; mem_y[1] = 7'd4;
        mem_x[2] = 7'd24; mem_y[2] = 7'd4;
        set_gen(50, 30, 50, 30);

        repeat (3) @(posedge CLOCK);
        #2;
        check_reset_outputs("reset");
        RESET_N = 1'b1;
        @(posedge CLOCK);
        #2;

        // Clean placement, body of three.
        issue(1, 0, 1, 50, 30, 0, 1, 6);
        wait_done(200);

        // First roll collides with idx 1, second roll is clear.
        set_gen(22, 4, 40, 10);
        issue(1, 0, 1, 40, 10, 0, 2, 11);
        wait_done(200);

        // Every candidate collides at idx 0: retry budget exhausted.
        mem_x[0] = 7'd18; mem_y[0] = 7'd2;
        set_gen(18, 2, 18, 2);
        issue(1, 0, 1, 18, 2, 1, 16, 64);
        wait_done(200);

        // Restart mid-SCAN: retry budget starts over from the restart edge.
        issue(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (9) @(posedge CLOCK);
        #2;
        check("restart_in_scan_busy", int'(busy), 1);
        issue(1, 0, 1, 18, 2, 1, 16, 64);
        @(negedge CLOCK);
        check("restart_step_next_cycle", int'(rand_step), 1);
        wait_done(200);
        mem_x[0] = 7'd20; mem_y[0] = 7'd4;

        // Eat begins a placement; a second eat while busy is ignored.
        set_gen(50, 30, 50, 30);
        issue(0, 1, 1, 50, 30, 0, 1, 6);
        repeat (2) @(posedge CLOCK);
        #2;
        eat = 1'b1;
        @(posedge CLOCK);
        #2;
        eat = 1'b0;
        wait_done(200);

        // Start and eat together with an empty body: no reads, immediate completion.
        snake_len = 6'd0;
        set_gen(7, 9, 7, 9);
        issue(1, 1, 1, 7, 9, 0, 1, 3);
        wait_done(200);

        // Oversized length clamps to 32 segments.
        snake_len = 6'd40;
        set_gen(50, 30, 50, 30);
        issue(1, 0, 1, 50, 30, 0, 1, 35);
        wait_done(200);

        // Length shrinking mid-scan has no effect on the scan in progress.
        snake_len = 6'd5;
        set_gen(61, 62, 61, 62);
        issue(1, 0, 1, 61, 62, 0, 1, 8);
        repeat (3) @(posedge CLOCK);
        #2;
        snake_len = 6'd1;
        wait_done(200);

        // Asynchronous reset mid-SCAN, then the block must stay idle.
        snake_len = 6'd3;
        set_gen(50, 30, 50, 30);
        issue(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge CLOCK);
        #2;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        saved = step_total;
        @(posedge CLOCK);
        #2;
        RESET_N = 1'b1;
        repeat (5) @(posedge CLOCK);
        #2;
        check("post_reset_busy", int'(busy), 0);
        check("post_reset_no_step", step_total, saved);
        check("post_reset_valid", int'(food_valid), 0);

        // The block works normally again after reset.
        issue(0, 1, 1, 50, 30, 0, 1, 6);
        wait_done(200);

        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule
